// File: rtl/seq_detect_prog_fsm.sv
// seq_detect_prog_fsm: runtime-programmable serial bit-sequence detector.
// A pattern of 1..LEN bits is loaded with cfg_load. The detector shifts in
// qualified bits and emits a registered one-cycle match pulse. It also keeps
// a saturating count of matches.
// Optional: define SEQ_DETECT_PROG_MASK_EN to add a per-bit don't-care mask
// (cfg_mask) that is captured together with the pattern.
module seq_detect_prog_fsm #(
    parameter int unsigned LEN     = 6,
    parameter int unsigned OVERLAP = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a,
    input  logic                       a_valid,
    input  logic                       cfg_load,
    input  logic [$clog2(LEN+1)-1:0]   cfg_len,
    input  logic [LEN-1:0]             cfg_pattern,
`ifdef SEQ_DETECT_PROG_MASK_EN
    input  logic [LEN-1:0]             cfg_mask,
`endif
    input  logic                       cnt_clr,
    output logic                       configured,
    output logic                       detected,
    output logic [CNT_W-1:0]           det_count
);

    localparam int unsigned LW = $clog2(LEN+1);

    typedef enum logic {
        UNCONF,
        HUNT
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [LEN-1:0]   r_pat, w_pat_nxt;
    logic [LEN-1:0]   r_hist, w_hist_nxt;
    logic [LW-1:0]    r_len, w_len_nxt;
    logic [LW-1:0]    r_fill, w_fill_nxt;
    logic             r_det, w_det_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [LEN-1:0]   w_cmp_mask;

    logic             w_cfg_ok;
    logic [LEN-1:0]   w_hist_shift;
    logic [LW-1:0]    w_fill_inc;
    logic [LEN-1:0]   w_len_mask;
    logic             w_hit;

`ifdef SEQ_DETECT_PROG_MASK_EN
    logic [LEN-1:0]   r_mask, w_mask_nxt;
    assign w_cmp_mask = r_mask;
`else
    assign w_cmp_mask = '1;
`endif

    assign w_cfg_ok     = cfg_load && (cfg_len != '0) && (cfg_len <= LW'(LEN));
    assign w_hist_shift = (r_hist << 1) | LEN'(a);
    assign w_fill_inc   = (r_fill == LW'(LEN)) ? r_fill : r_fill + LW'(1);

    // Compare window: only the low r_len history bits take part
    always_comb begin
        w_len_mask = '0;
        for (int unsigned i = 0; i < LEN; i++) begin
            w_len_mask[i] = (i < 32'(r_len));
        end
    end

    // A bit is a match when enough bits have been seen and the masked window equals the pattern
    assign w_hit = (r_state == HUNT) && !w_cfg_ok && a_valid &&
                   (w_fill_inc >= r_len) &&
                   (((w_hist_shift ^ r_pat) & w_len_mask & w_cmp_mask) == '0);

    // State, configuration and history registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= UNCONF;
            r_pat   <= '0;
            r_hist  <= '0;
            r_len   <= '0;
            r_fill  <= '0;
            r_det   <= 1'b0;
            r_cnt   <= '0;
`ifdef SEQ_DETECT_PROG_MASK_EN
            r_mask  <= '1;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_hist  <= w_hist_nxt;
            r_len   <= w_len_nxt;
            r_fill  <= w_fill_nxt;
            r_det   <= w_det_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef SEQ_DETECT_PROG_MASK_EN
            r_mask  <= w_mask_nxt;
`endif
        end
    end

    // Next-state, history update, match pulse and saturating counter
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_hist_nxt  = r_hist;
        w_len_nxt   = r_len;
        w_fill_nxt  = r_fill;
        w_det_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;
`ifdef SEQ_DETECT_PROG_MASK_EN
        w_mask_nxt  = r_mask;
`endif

        if (w_cfg_ok) begin
            // A legal load (re)programs from either state; the same-cycle data bit is dropped
            w_state_nxt = HUNT;
            w_pat_nxt   = cfg_pattern;
            w_len_nxt   = cfg_len;
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
`ifdef SEQ_DETECT_PROG_MASK_EN
            w_mask_nxt  = cfg_mask;
`endif
        end else begin
            case (r_state)
                UNCONF: begin
                    w_state_nxt = UNCONF;
                end
                HUNT: begin
                    if (a_valid) begin
                        w_hist_nxt = w_hist_shift;
                        w_fill_nxt = (w_hit && (OVERLAP == 0)) ? '0 : w_fill_inc;
                        w_det_nxt  = w_hit;
                    end
                end
                default: begin
                    w_state_nxt = UNCONF;
                end
            endcase
        end

        if (cnt_clr) begin
            w_cnt_nxt = '0;
        end else if (w_hit && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    assign configured = (r_state == HUNT);
    assign detected   = r_det;
    assign det_count  = r_cnt;

endmodule

// File: tb/tb_seq_detect_prog_fsm.sv
// Testbench for seq_detect_prog_fsm. Three instances share one stimulus:
// (OVERLAP=1,CNT_W=8), (OVERLAP=0,CNT_W=8) and (OVERLAP=1,CNT_W=2).
// A queue-based reference model predicts their outputs.
module tb_seq_detect_prog_fsm;

    logic       clk;
    logic       rst;
    logic       a;
    logic       a_valid;
    logic       cfg_load;
    logic [2:0] cfg_len;
    logic [5:0] cfg_pattern;
    logic       cnt_clr;

    logic       conf0, conf1, conf2;
    logic       det0, det1, det2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int n_checks = 0;
    int n_err    = 0;

    seq_detect_prog_fsm #(.LEN(6), .OVERLAP(1), .CNT_W(8)) dut_ov (
        .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .cfg_load(cfg_load),
        .cfg_len(cfg_len), .cfg_pattern(cfg_pattern),
`ifdef SEQ_DETECT_PROG_MASK_EN
        .cfg_mask(6'h3f),
`endif
        .cnt_clr(cnt_clr), .configured(conf0), .detected(det0), .det_count(cnt0));

    seq_detect_prog_fsm #(.LEN(6), .OVERLAP(0), .CNT_W(8)) dut_nov (
        .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .cfg_load(cfg_load),
        .cfg_len(cfg_len), .cfg_pattern(cfg_pattern),
`ifdef SEQ_DETECT_PROG_MASK_EN
        .cfg_mask(6'h3f),
`endif
        .cnt_clr(cnt_clr), .configured(conf1), .detected(det1), .det_count(cnt1));

    seq_detect_prog_fsm #(.LEN(6), .OVERLAP(1), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .cfg_load(cfg_load),
        .cfg_len(cfg_len), .cfg_pattern(cfg_pattern),
`ifdef SEQ_DETECT_PROG_MASK_EN
        .cfg_mask(6'h3f),
`endif
        .cnt_clr(cnt_clr), .configured(conf2), .detected(det2), .det_count(cnt2));

    logic [23:0] w_obs;
    assign w_obs = {conf0, conf1, conf2, det0, det1, det2, cnt0, cnt1, cnt2};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: queues of valid bits seen since (re)configuration
    bit          m_conf;
    int          m_len;
    logic [5:0]  m_pat;
    bit          qo[$];
    bit          qn[$];
    bit          e0, e1, e2;
    int          c0, c1, c2;
    logic [23:0] m_exp;

    function automatic bit tail_matches(input bit q[$]);
        if (q.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (q[q.size() - 1 - i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_pack();
        m_exp = {m_conf, m_conf, m_conf, e0, e1, e2, 8'(c0), 8'(c1), 2'(c2)};
    endfunction

    function automatic void model_reset();
        m_conf = 1'b0;
        m_len  = 0;
        m_pat  = '0;
        qo.delete();
        qn.delete();
        e0 = 0; e1 = 0; e2 = 0;
        c0 = 0; c1 = 0; c2 = 0;
        model_pack();
    endfunction

    function automatic void model_step();
        bit ho, hn;
        ho = 0;
        hn = 0;
        if (cfg_load && cfg_len >= 1 && cfg_len <= 6) begin
            m_conf = 1'b1;
            m_len  = int'(cfg_len);
            m_pat  = cfg_pattern;
            qo.delete();
            qn.delete();
        end else if (m_conf && a_valid) begin
            qo.push_back(a);
            if (qo.size() > 6) void'(qo.pop_front());
            ho = tail_matches(qo);
            qn.push_back(a);
            if (qn.size() > 6) void'(qn.pop_front());
            hn = tail_matches(qn);
            if (hn) qn.delete();
        end
        e0 = ho; e1 = hn; e2 = ho;
        if (cnt_clr) begin
            c0 = 0; c1 = 0; c2 = 0;
        end else begin
            if (ho && c0 < 255) c0++;
            if (hn && c1 < 255) c1++;
            if (ho && c2 < 3)   c2++;
        end
        model_pack();
    endfunction

    // Drive one clock of stimulus, advance the model, and settle 1 time unit after the edge
    task automatic drive_cycle(input logic ia, input logic iv, input logic il,
                               input logic [2:0] ilen, input logic [5:0] ipat, input logic iclr);
        a           = ia;
        a_valid     = iv;
        cfg_load    = il;
        cfg_len     = ilen;
        cfg_pattern = ipat;
        cnt_clr     = iclr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #2;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a = 0; a_valid = 0; cfg_load = 0; cfg_len = '0; cfg_pattern = '0; cnt_clr = 0;
        model_reset();
        #12;
        n_checks++;
        if (w_obs !== m_exp) begin
            n_err++;
            $display("FAIL reset_state actual=%h expected=%h", w_obs, m_exp);
        end
        n_checks++;
        if (w_obs !== 24'h0) begin
            n_err++;
            $display("FAIL reset_zero actual=%h expected=%h", w_obs, 24'h0);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_overlap();
        logic [9:0] stream;
        stream = 10'b1100110011;
        drive_cycle(0, 0, 1, 3'd6, 6'b110011, 1);
        for (int i = 9; i >= 0; i--) begin
            drive_cycle(stream[i], 1, 0, 3'd0, 6'd0, 0);
            n_checks++;
            if (w_obs !== m_exp) begin
                n_err++;
                $display("FAIL overlap bit=%0d actual=%h expected=%h", 10 - i, w_obs, m_exp);
            end
        end
        n_checks++;
        if (cnt0 !== 8'd2 || cnt1 !== 8'd1) begin
            n_err++;
            $display("FAIL overlap_counts actual=%0d/%0d expected=2/1", cnt0, cnt1);
        end
    endtask

    task automatic test_valid_gaps();
        logic [5:0] stream;
        stream = 6'b101010;
        drive_cycle(0, 0, 1, 3'd4, 6'b001010, 1);
        for (int i = 5; i >= 0; i--) begin
            drive_cycle(stream[i], 1, 0, 3'd0, 6'd0, 0);
            n_checks++;
            if (w_obs !== m_exp) begin
                n_err++;
                $display("FAIL gaps_valid bit=%0d actual=%h expected=%h", 6 - i, w_obs, m_exp);
            end
            drive_cycle(1'($urandom), 0, 0, 3'd0, 6'd0, 0);
            n_checks++;
            if (w_obs !== m_exp || det0 !== 1'b0) begin
                n_err++;
                $display("FAIL gaps_idle bit=%0d actual=%h expected=%h", 6 - i, w_obs, m_exp);
            end
        end
        n_checks++;
        if (cnt0 !== 8'd2) begin
            n_err++;
            $display("FAIL gaps_count actual=%0d expected=2", cnt0);
        end
    endtask

    task automatic test_saturate();
        int want [5] = '{1, 2, 3, 3, 3};
        drive_cycle(0, 0, 1, 3'd1, 6'b000001, 1);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1, 1, 0, 3'd0, 6'd0, 0);
            n_checks++;
            if (w_obs !== m_exp || cnt2 !== 2'(want[i])) begin
                n_err++;
                $display("FAIL saturate match=%0d actual=%h/%0d expected=%h/%0d",
                         i + 1, w_obs, cnt2, m_exp, want[i]);
            end
        end
        drive_cycle(1, 1, 0, 3'd0, 6'd0, 1);
        n_checks++;
        if (w_obs !== m_exp || cnt2 !== 2'd0 || det2 !== 1'b1) begin
            n_err++;
            $display("FAIL clear_wins actual=%h expected=%h", w_obs, m_exp);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        drive_cycle(0, 0, 1, 3'd0, 6'b111111, 0);
        drive_cycle(1, 1, 0, 3'd0, 6'd0, 0);
        drive_cycle(0, 0, 1, 3'd7, 6'b111111, 0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1, 1, 0, 3'd0, 6'd0, 0);
            n_checks++;
            if (w_obs !== m_exp || conf0 !== 1'b0 || det0 !== 1'b0) begin
                n_err++;
                $display("FAIL illegal_unconf bit=%0d actual=%h expected=%h", i, w_obs, m_exp);
            end
        end
        drive_cycle(1, 1, 1, 3'd2, 6'b000011, 0);
        n_checks++;
        if (w_obs !== m_exp || conf0 !== 1'b1 || det0 !== 1'b0) begin
            n_err++;
            $display("FAIL legal_after_illegal actual=%h expected=%h", w_obs, m_exp);
        end
        drive_cycle(0, 0, 1, 3'd0, 6'b000000, 0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 1, 0, 3'd0, 6'd0, 0);
            n_checks++;
            if (w_obs !== m_exp) begin
                n_err++;
                $display("FAIL illegal_in_hunt bit=%0d actual=%h expected=%h", i, w_obs, m_exp);
            end
        end
    endtask

    task automatic test_midreset();
        logic [5:0] stream;
        stream = 6'b110011;
        apply_reset();
        drive_cycle(0, 0, 1, 3'd6, 6'b110011, 1);
        for (int i = 5; i >= 1; i--) begin
            drive_cycle(stream[i], 1, 0, 3'd0, 6'd0, 0);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (w_obs !== 24'h0) begin
            n_err++;
            $display("FAIL async_reset actual=%h expected=%h", w_obs, 24'h0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_cycle(0, 0, 1, 3'd6, 6'b110011, 0);
        drive_cycle(stream[0], 1, 0, 3'd0, 6'd0, 0);
        n_checks++;
        if (w_obs !== m_exp || det0 !== 1'b0 || det1 !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset_no_match actual=%h expected=%h", w_obs, m_exp);
        end
    endtask

    task automatic test_random();
        logic       il, iv, ia, iclr;
        logic [2:0] ilen;
        logic [5:0] ipat;
        for (int n = 0; n < 400; n++) begin
            il   = ($urandom_range(0, 19) == 0);
            ilen = 3'($urandom_range(0, 7));
            if (ilen > 3'd4 && $urandom_range(0, 1) == 1) ilen = 3'($urandom_range(1, 3));
            ipat = 6'($urandom);
            iv   = ($urandom_range(0, 3) != 0);
            if (il && (ilen == 3'd0 || ilen == 3'd7)) iv = 1'b0;
            ia   = 1'($urandom);
            iclr = ($urandom_range(0, 29) == 0);
            drive_cycle(ia, iv, il, ilen, ipat, iclr);
            n_checks++;
            if (w_obs !== m_exp) begin
                n_err++;
                $display("FAIL random cyc=%0d actual=%h expected=%h", n, w_obs, m_exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_valid_gaps();
        test_saturate();
        test_illegal();
        test_midreset();
        apply_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog_fsm.md
Name: seq_detect_prog_fsm

Overview:
- Runtime-programmable serial bit-sequence detector; parametrised successor to the fixed-pattern detector FSMs in the FSM block set.
- Pattern length is 1..LEN, loaded through a config strobe.
- Supports overlapping or non-overlapping matches, a qualified input stream (`a_valid`) and a saturating match counter.
- Sits between a serial bit source and control logic that consumes match pulses.

Parameters:
- LEN, 6, maximum pattern length in bits (legal range 1..32).
- OVERLAP, 1, 1 = a match's trailing bits may start the next match; 0 = history is discarded after each match.
- CNT_W, 8, width of the saturating match counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserts immediately, releases on the clk edge).
- a  input  1  serial data bit.
- a_valid  input  1  `a` is sampled only when 1.
- cfg_load  input  1  one-cycle strobe; captures `cfg_pattern` and `cfg_len`.
- cfg_len  input  $clog2(LEN+1)  pattern length, 1..LEN.
- cfg_pattern  input  LEN  pattern; bit [cfg_len-1] is the first bit expected, bit [0] the last.
- cnt_clr  input  1  synchronous clear of `det_count`.
- configured  output  1  1 once a legal pattern has been loaded.
- detected  output  1  registered one-cycle match pulse.
- det_count  output  CNT_W  number of matches, saturating.

Behaviour:
- Reset (rst=0):
  - State = UNCONF.
  - Pattern, length, history and fill registers cleared.
  - `configured`=0, `detected`=0, `det_count`=0.
- States:
  - UNCONF: ignores `a`. A legal `cfg_load` -> HUNT.
  - HUNT: shifts in `a` on each cycle with `a_valid`=1. A `cfg_load` stays in HUNT and reprograms.
- Illegal `cfg_load` (`cfg_len`=0 or `cfg_len`>LEN):
  - Ignored; state and all registers unchanged.
  - In UNCONF it remains UNCONF.
- Legal `cfg_load`:
  - Next cycle: new pattern/length active, history and fill cleared, `configured`=1.
  - An `a_valid` bit arriving in the same cycle as `cfg_load` is discarded.
  - `det_count` is not affected.
- History update (HUNT, `a_valid`=1):
  - history <= {history[LEN-2:0], a}.
  - fill <= min(fill+1, LEN).
- Match condition:
  - fill_next >= cfg_len, and history_next[cfg_len-1:0] == pattern[cfg_len-1:0].
  - On match, `detected`=1 in the cycle after the sampling edge (1-cycle latency, Moore-style registered output). Held exactly 1 cycle unless the next bit also matches.
- `a_valid`=0:
  - History and fill frozen.
  - `detected` deasserts the following cycle.
- OVERLAP=0: on a match, fill <= 0 (history bits kept but unusable until cfg_len new bits arrive).
- OVERLAP=1: fill unchanged on a match.
- Counter:
  - `det_count` increments by 1 on each match; holds at 2^CNT_W-1 when saturated.
  - `cnt_clr` and a match in the same cycle: result is 0 (clear wins).
- Mid-operation reset: all outputs drop on rst assertion, without waiting for clk.
- No X propagation: all registers are reset; the comparison is masked to `cfg_len` bits.

Optional Feature:
- Macro: SEQ_DETECT_PROG_MASK_EN.
- Defined:
  - Adds input `cfg_mask` [LEN-1:0], captured together with `cfg_pattern` on `cfg_load`.
  - Bit positions with mask=0 are don't-care in the comparison.
  - `cfg_mask` reset value: all ones.
- Undefined:
  - `cfg_mask` port absent.
  - All `cfg_len` bits are compared exactly.

Test Plan:
- LEN=6, OVERLAP=1; load `cfg_len`=6, pattern 6'b110011; stream 1,1,0,0,1,1,0,0,1,1 with `a_valid`=1 -> `detected` pulses the cycle after bits 6 and 10; `det_count`=2.
- Same stream with OVERLAP=0 -> single pulse after bit 6; `det_count`=1.
- `cfg_len`=4, pattern 4'b1010; stream 1,0,1,0,1,0 with `a_valid` low every other cycle -> pulses after the 4th and 6th valid bits; `detected` deasserts during invalid cycles.
- CNT_W=2; 5 matches -> `det_count` = 1,2,3,3,3. Then assert `cnt_clr` in the same cycle as a 6th match -> `det_count`=0.
- `cfg_load` with `cfg_len`=0 from UNCONF -> `configured` stays 0; stream 1,1,1,1 gives no pulse. Then a legal load -> `configured`=1 on the next cycle.
- Mid-stream: assert rst after 5 bits of 110011 -> outputs 0 immediately; state UNCONF. After reload, the 6th bit alone does not match.
